if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues word fetches to instruction memory over a req/gnt/rvalid

---
 rtl/if_fetch_unit_pkg.sv | 27 ++
 rtl/if_fetch_unit_if.sv | 13 +
 rtl/if_skid_buffer.sv | 30 +++
 rtl/if_fetch_unit.sv | 113 +++++++++++
 tb/tb_if_fetch_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, fetch payload, NOP constant.
package if_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Word-align a redirect target.
    function automatic word_t align_pc(input word_t a);
        return a & ~word_t'(3);
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid handshake between fetch (master) and memory (slave).
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic  req;
    word_t addr;
    logic  gnt;
    logic  rvalid;
    word_t rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry {pc, instr} holding register that absorbs a response while decode stalls.
module if_skid_buffer
    import if_fetch_unit_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_unload,
    input  logic         i_clear,
    input  fetch_entry_t i_d,
    output logic         o_full,
    output fetch_entry_t o_q
);

    // Clear wins over load so a redirect never leaves a stale entry behind.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_full <= 1'b0;
            o_q    <= '0;
        end else if (i_clear) begin
            o_full <= 1'b0;
        end else if (i_load) begin
            o_full <= 1'b1;
            o_q    <= i_d;
        end else if (i_unload) begin
            o_full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem fetch, IF/ID output slot with skid.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    input  word_t                  i_redirect_pc,
    input  logic                   i_halt,
    if_fetch_unit_if.master        imem,
    output logic                   o_valid,
    output word_t                  o_pc,
    output word_t                  o_pc_plus_4,
    output word_t                  o_instruction
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, inflight_pc_q;
    logic         req_q;
    logic         skid_full;
    fetch_entry_t skid_q;

    logic consumed, slot_free, deliver, skid_load, skid_unload, skid_full_nxt;

    assign consumed      = o_valid & ~i_stall;
    assign slot_free     = ~o_valid | ~i_stall;
    assign deliver       = (state_q == ST_WAIT) & imem.rvalid & ~i_redirect;
    assign skid_load     = deliver & ~slot_free;
    assign skid_unload   = skid_full & consumed & ~i_redirect;
    assign skid_full_nxt = ~i_redirect & (skid_load | (skid_full & ~consumed));

    assign imem.req  = req_q;
    assign imem.addr = pc_q;

    // Next state; a redirect decides whether the outstanding fetch must be drained.
    always_comb begin
        state_d = state_q;
        if (i_redirect) begin
            case (state_q)
                ST_IDLE:  state_d = i_halt ? ST_IDLE : ST_REQ;
                ST_REQ:   state_d = imem.gnt ? ST_DRAIN : ST_REQ;
                ST_WAIT,
                ST_DRAIN: state_d = imem.rvalid ? (i_halt ? ST_IDLE : ST_REQ) : ST_DRAIN;
            endcase
        end else begin
            case (state_q)
                ST_IDLE:  if (!i_halt && !skid_full) state_d = ST_REQ;
                ST_REQ:   if (imem.gnt) state_d = ST_WAIT;
                ST_WAIT:  if (imem.rvalid) state_d = (!i_halt && !skid_full_nxt) ? ST_REQ : ST_IDLE;
                ST_DRAIN: if (imem.rvalid) state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= (state_d == ST_REQ);
            if (i_redirect) begin
                pc_q <= align_pc(i_redirect_pc);
            end else if (state_q == ST_REQ && imem.gnt) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + word_t'(4);
            end
        end
    end

    // IF/ID output slot; the skid entry refills it ahead of any new response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid       <= 1'b0;
            o_pc          <= RESET_PC;
            o_pc_plus_4   <= RESET_PC + word_t'(4);
            o_instruction <= NOP_INSTR;
        end else if (i_redirect) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
        end else if (skid_unload) begin
            o_valid       <= 1'b1;
            o_pc          <= skid_q.pc;
            o_pc_plus_4   <= skid_q.pc + word_t'(4);
            o_instruction <= skid_q.instr;
        end else if (deliver && slot_free) begin
            o_valid       <= 1'b1;
            o_pc          <= inflight_pc_q;
            o_pc_plus_4   <= inflight_pc_q + word_t'(4);
            o_instruction <= imem.rdata;
        end else if (consumed) begin
            o_valid       <= 1'b0;
            o_instruction <= NOP_INSTR;
        end
    end

    if_skid_buffer u_skid (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (skid_load),
        .i_unload (skid_unload),
        .i_clear  (i_redirect),
        .i_d      ('{pc: inflight_pc_q, instr: imem.rdata}),
        .o_full   (skid_full),
        .o_q      (skid_q)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed cycle-table and hand-sequenced checks for the instruction-fetch stage.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    localparam word_t NOP = 32'h0000_0013;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  stall, redirect, halt;
    word_t redirect_pc;
    logic  o_valid;
    word_t o_pc, o_pc_plus_4, o_instruction;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_halt        (halt),
        .imem          (imem.master),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_pc_plus_4   (o_pc_plus_4),
        .o_instruction (o_instruction)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  stall, redir;
        word_t rpc;
        logic  halt, gnt, rvalid;
        word_t rdata;
        logic  e_req;
        word_t e_addr;
        logic  e_valid;
        word_t e_pc, e_instr;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic s, input logic r, input word_t rpc, input logic h,
                                input logic g, input logic rv, input word_t rd,
                                input logic ereq, input word_t eaddr, input logic ev,
                                input word_t epc, input word_t einstr);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.halt = h; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_pc = epc; v.e_instr = einstr;
        return v;
    endfunction

    task automatic chk(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic r, input word_t rpc, input logic h,
                         input logic g, input logic rv, input word_t rd);
        stall = s; redirect = r; redirect_pc = rpc; halt = h;
        imem.gnt = g; imem.rvalid = rv; imem.rdata = rd;
    endtask

    // Drive one cycle's inputs and advance to the next sampling point.
    task automatic step(input logic s, input logic r, input word_t rpc, input logic h,
                        input logic g, input logic rv, input word_t rd);
        drive(s, r, rpc, h, g, rv, rd);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req"},   32'(imem.req), 32'd0);
        chk({tag, " valid"}, 32'(o_valid), 32'd0);
        chk({tag, " pc"},    o_pc, 32'h0);
        chk({tag, " pc4"},   o_pc_plus_4, 32'h4);
        chk({tag, " instr"}, o_instruction, NOP);
        chk({tag, " addr"},  imem.addr, 32'h0);
    endtask

    initial begin
        //            stl red rpc       hlt gnt rv  rdata          | req addr     vld pc         instr
        vecs[0]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
        vecs[1]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h0,   0, 32'h0,   NOP);
        vecs[2]  = mk(0, 0, 32'h0,   0, 1, 1, 32'hA000_0000,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[3]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h4,   1, 32'h0,   32'hA000_0000);
        vecs[4]  = mk(0, 0, 32'h0,   0, 1, 1, 32'hA000_0004,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[5]  = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h8,   1, 32'h4,   32'hA000_0004);
        vecs[6]  = mk(1, 0, 32'h0,   0, 1, 1, 32'hA000_0008,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[7]  = mk(1, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'hC,   1, 32'h8,   32'hA000_0008);
        vecs[8]  = mk(1, 0, 32'h0,   0, 0, 1, 32'hA000_000C,  0, 32'h0,   1, 32'h8,   32'hA000_0008);
        vecs[9]  = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   1, 32'h8,   32'hA000_0008);
        vecs[10] = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   1, 32'h8,   32'hA000_0008);
        vecs[11] = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   1, 32'h8,   32'hA000_0008);
        vecs[12] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   1, 32'h8,   32'hA000_0008);
        vecs[13] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   1, 32'hC,   32'hA000_000C);
        vecs[14] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h10,  0, 32'h0,   NOP);
        vecs[15] = mk(0, 0, 32'h0,   0, 0, 1, 32'hA000_0010,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[16] = mk(0, 1, 32'h22,  0, 0, 0, 32'h0,          1, 32'h14,  1, 32'h10,  32'hA000_0010);
        vecs[17] = mk(0, 1, 32'h103, 0, 1, 0, 32'h0,          1, 32'h20,  0, 32'h0,   NOP);
        vecs[18] = mk(0, 0, 32'h0,   0, 0, 1, 32'hA000_0020,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[19] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
        vecs[20] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h100, 0, 32'h0,   NOP);
        vecs[21] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,          0, 32'h0,   0, 32'h0,   NOP);
        vecs[22] = mk(0, 1, 32'h200, 0, 0, 1, 32'hA000_0100,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[23] = mk(0, 0, 32'h0,   0, 1, 0, 32'h0,          1, 32'h200, 0, 32'h0,   NOP);
        vecs[24] = mk(0, 0, 32'h0,   0, 0, 1, 32'hA000_0200,  0, 32'h0,   0, 32'h0,   NOP);
        vecs[25] = mk(1, 1, 32'h300, 0, 0, 0, 32'h0,          1, 32'h204, 1, 32'h200, 32'hA000_0200);
        vecs[26] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,          1, 32'h300, 0, 32'h0,   NOP);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Cycle table: steady fetch, stall into skid, redirects in REQ/gnt, WAIT/rvalid, and stalled slot.
        for (int i = 0; i < 27; i++) begin
            chk($sformatf("v%0d req", i),   32'(imem.req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) chk($sformatf("v%0d addr", i), imem.addr, vecs[i].e_addr);
            chk($sformatf("v%0d valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d pc", i),  o_pc, vecs[i].e_pc);
                chk($sformatf("v%0d pc4", i), o_pc_plus_4, vecs[i].e_pc + 32'd4);
            end
            chk($sformatf("v%0d instr", i), o_instruction, vecs[i].e_instr);
            drive(vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].halt,
                  vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            @(negedge clk);
        end

        // PC wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'h0);
        chk("wrap req",  32'(imem.req), 32'd1);
        chk("wrap addr", imem.addr, 32'hFFFF_FFFC);
        step(0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("wrap wait req", 32'(imem.req), 32'd0);
        step(0, 0, 32'h0, 0, 0, 1, 32'h1234_5678);
        chk("wrap valid", 32'(o_valid), 32'd1);
        chk("wrap pc",    o_pc, 32'hFFFF_FFFC);
        chk("wrap pc4",   o_pc_plus_4, 32'h0);
        chk("wrap instr", o_instruction, 32'h1234_5678);
        chk("wrap next addr", imem.addr, 32'h0);

        // Halt: a raised REQ completes, outstanding fetch delivers, no new issue.
        step(0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("halt req after gnt", 32'(imem.req), 32'd0);
        step(0, 0, 32'h0, 1, 0, 1, 32'h0000_0ABC);
        chk("halt valid", 32'(o_valid), 32'd1);
        chk("halt pc",    o_pc, 32'h0);
        chk("halt instr", o_instruction, 32'h0000_0ABC);
        chk("halt req0",  32'(imem.req), 32'd0);
        step(0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("halt req1", 32'(imem.req), 32'd0);
        step(0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("halt req2", 32'(imem.req), 32'd0);
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("resume req",  32'(imem.req), 32'd1);
        chk("resume addr", imem.addr, 32'h4);

        // Park a valid stalled slot with a fetch in WAIT, then reset asynchronously.
        step(1, 0, 32'h0, 0, 1, 0, 32'h0);
        step(1, 0, 32'h0, 0, 0, 1, 32'hDEAD_0004);
        chk("pre-rst pc", o_pc, 32'h4);
        step(1, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("pre-rst valid", 32'(o_valid), 32'd1);
        chk("pre-rst req",   32'(imem.req), 32'd0);
        drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Responses arriving before the first post-reset gnt are ignored.
        step(0, 0, 32'h0, 0, 0, 1, 32'h0000_0BAD);
        chk("post-rst valid", 32'(o_valid), 32'd0);
        chk("post-rst req",   32'(imem.req), 32'd1);
        chk("post-rst addr",  imem.addr, 32'h0);
        step(0, 0, 32'h0, 0, 0, 1, 32'h0000_0BAD);
        chk("post-rst valid2", 32'(o_valid), 32'd0);
        chk("post-rst addr2",  imem.addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
